// File: rtl/div3_scan_ctrl_if.sv
// rtl/div3_scan_ctrl_if.sv - control, detector and hit-stream signals of the div3 scan sequencer
interface div3_scan_ctrl_if #(
    parameter int VAL_W = 4,
    parameter int CNT_W = 5
);
    // Scan request from the control source
    logic             start;
    logic [VAL_W-1:0] lo;
    logic [VAL_W-1:0] hi;

    // Link to the external combinational detector
    logic [VAL_W-1:0] dp_val;
    logic             dp_match;

    // Hit stream
    logic             hit_valid;
    logic             hit_ready;
    logic [VAL_W-1:0] hit_data;

    // Status
    logic [CNT_W-1:0] hit_count;
    logic             busy;
    logic             done;

    // The sequencer itself
    modport slave (
        input  start, lo, hi, dp_match, hit_ready,
        output dp_val, hit_valid, hit_data, hit_count, busy, done
    );

    // Everything around the sequencer: control source, detector, hit consumer
    modport master (
        output start, lo, hi, dp_match, hit_ready,
        input  dp_val, hit_valid, hit_data, hit_count, busy, done
    );
endinterface

// File: rtl/div3_scan_ctrl.sv
// rtl/div3_scan_ctrl.sv - steps a candidate range through a divisible-by-3 detector and streams the hits
module div3_scan_ctrl #(
    parameter int VAL_W = 4,    // must match the 4-bit detector; other widths unsupported
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    div3_scan_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_EMIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [VAL_W-1:0] cur_q,       cur_d;
    logic [VAL_W-1:0] hi_q,        hi_d;
    logic [VAL_W-1:0] hit_data_q,  hit_data_d;
    logic             hit_valid_q, hit_valid_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;

    // End-of-range is tested before any increment so hi = max never wraps cur to 0
    logic last_cand;
    assign last_cand = (cur_q == hi_q);

    // Next-state and datapath updates; every register holds unless a state moves it
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        hi_d        = hi_q;
        hit_data_d  = hit_data_q;
        hit_valid_d = hit_valid_q;
        hit_count_d = hit_count_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    hi_d        = bus.hi;
                    hit_count_d = '0;
                    if (bus.lo > bus.hi) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = bus.lo;
                        state_d = S_EVAL;
                    end
                end
            end

            S_EVAL: begin
                // dp_match belongs to the dp_val = cur_q presented this cycle
                if (bus.dp_match) begin
                    hit_data_d  = cur_q;
                    hit_valid_d = 1'b1;
                    hit_count_d = hit_count_q + CNT_W'(1);
                    state_d     = S_EMIT;
                end else if (last_cand) begin
                    state_d = S_DONE;
                end else begin
                    cur_d = cur_q + VAL_W'(1);
                end
            end

            S_EMIT: begin
                // Hold the hit and the candidate until the consumer takes it
                if (bus.hit_ready) begin
                    hit_valid_d = 1'b0;
                    if (last_cand) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = cur_q + VAL_W'(1);
                        state_d = S_EVAL;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending hit without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            hi_q        <= '0;
            hit_data_q  <= '0;
            hit_valid_q <= 1'b0;
            hit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            hi_q        <= hi_d;
            hit_data_q  <= hit_data_d;
            hit_valid_q <= hit_valid_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign bus.dp_val    = cur_q;
    assign bus.hit_data  = hit_data_q;
    assign bus.hit_valid = hit_valid_q;
    assign bus.hit_count = hit_count_q;
    assign bus.busy      = (state_q == S_EVAL) || (state_q == S_EMIT);
    assign bus.done      = (state_q == S_DONE);

endmodule

// File: doc/div3_scan_ctrl.md
Name: div3_scan_ctrl

Overview:
- Sequencer for the 4-bit combinational divisible-by-3 detector (inputs A,B,C,D with A = MSB; output Out = 1 for 0, 3, 6, 9, 12, 15).
- On a start pulse, steps a candidate value from a lower to an upper bound and presents one value per cycle to the detector.
- Samples the detector result and emits every matching value on a valid/ready stream. Counts the hits and flags completion.
- Sits between a test/control source (switches, processor, bench) and the detector instance, which is external and wired to dp_val/dp_match.

Parameters:
- VAL_W, 4, candidate width; fixed to the detector width, other values unsupported.
- CNT_W, 5, width of hit_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle scan request; honoured only in IDLE.
- lo  input  VAL_W  lower bound, inclusive; sampled with start.
- hi  input  VAL_W  upper bound, inclusive; sampled with start.
- dp_val  output  VAL_W  registered candidate to the detector: bit3 = A, bit0 = D.
- dp_match  input  1  detector Out for the current dp_val.
- hit_valid  output  1  hit_data holds a matching value.
- hit_ready  input  1  consumer accepts the hit.
- hit_data  output  VAL_W  matching value.
- hit_count  output  CNT_W  hits in the current or last scan.
- busy  output  1  scan in progress (EVAL or EMIT).
- done  output  1  one-cycle pulse at scan end.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state = IDLE; dp_val, hit_data, hit_count, cur, hi_q = 0; hit_valid, busy, done = 0.
- dp_val always equals the internal cur register. The detector is combinational, so dp_match is valid in the same cycle dp_val is stable.
- IDLE:
  - start = 1 latches hi into hi_q and clears hit_count.
  - If lo > hi, go to DONE.
  - Otherwise set cur = lo and go to EVAL.
  - start = 0: remain in IDLE. dp_val, hit_data and hit_count hold their values.
- EVAL (busy = 1), one candidate per cycle:
  - dp_match = 1: set hit_data = cur, hit_valid = 1, hit_count + 1, and go to EMIT.
  - dp_match = 0 and cur == hi_q: go to DONE.
  - dp_match = 0 and cur != hi_q: cur + 1, remain in EVAL.
- EMIT (busy = 1):
  - hit_valid stays high, and hit_data and cur stay stable, until hit_ready = 1.
  - On a cycle with hit_valid and hit_ready both high: clear hit_valid.
  - Then, if cur == hi_q, go to DONE; otherwise cur + 1 and go to EVAL.
  - hit_ready is ignored outside EMIT. hit_valid never rises combinationally from hit_ready.
- DONE:
  - done = 1 for exactly one cycle, busy = 0, then go to IDLE.
  - hit_count holds until the next accepted start.
- No wrap-around:
  - The end-of-range test precedes any increment, so hi = 15 ends after evaluating 15.
  - cur never wraps to 0.
- A start pulse while busy or in DONE is ignored. Changes on lo/hi after start have no effect.
- Busy duration for lo <= hi = (hi − lo + 1) EVAL cycles + one EMIT cycle per hit + stall cycles (cycles in EMIT with hit_ready low).
- Reset asserted mid-scan:
  - Immediate return to reset values; any pending hit is discarded, with no done pulse.
  - The scan resumes only on a new start after reset release.

Test Plan:
- Full range: lo = 0, hi = 15, hit_ready tied 1, real detector connected -> hits 0, 3, 6, 9, 12, 15 in order; hit_count = 6; busy high 22 cycles; single done pulse; dp_val never exceeds 15 or wraps.
- Single non-match: lo = hi = 7 -> one EVAL cycle, no hit_valid, hit_count = 0, done the cycle after EVAL.
- Empty range: lo = 9, hi = 5 -> busy never high, done one cycle after start, hit_count = 0, no hits.
- Backpressure: lo = 2, hi = 7, hit_ready low for 3 cycles when hit 3 appears -> hit_valid and hit_data = 3 held, dp_val stays 3 during the stall; then hit 6; hit_count = 2; busy = 6 + 2 + 3 = 11 cycles.
- Start while busy and bound change: pulse start again and change lo/hi mid-scan of lo = 0, hi = 15 -> no effect, the original 6 hits are produced.
- Reset mid-scan: assert rst_n low while in EMIT with hit_data = 6 -> outputs immediately at reset values, no done; after release, idle until start; a new scan lo = 12, hi = 15 gives hits 12, 15 and count 2.
